// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU front end: the default datapath width and the
// state encoding of the instruction-fetch queue controller.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Default address / instruction width of the core.
  localparam int XLEN_DEFAULT = 32;

  // Fetch controller states:
  //   ST_BOOT    - one idle cycle after reset release, no requests
  //   ST_RUN     - normal fetching
  //   ST_DISCARD - a redirect left a response pending; drop it when it lands
  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Queue storage: DEPTH words of WIDTH bits, one synchronous write port and one
// asynchronous read port. Contents are not reset; the owner tracks validity.
//
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store one entry per enabled clock.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_ram

// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
// Instruction fetch unit with a small decoupling queue. Owns the fetch PC,
// issues one word request per cycle while the queue has room, captures
// responses (one cycle after the request) into a FIFO, and presents the head
// entry to decode. A redirect flushes the queue and restarts fetching at the
// new target; a response still outstanding at that moment is discarded.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_req       out  fetch request this cycle
//   imem_addr      out  fetch address (word aligned)
//   imem_valid     in   response valid, one cycle after imem_req
//   imem_data      in   returned instruction word
//   redirect_valid in   taken branch/jump: flush and refetch
//   redirect_pc    in   new fetch target (low two bits ignored)
//   out_valid      out  queue head valid
//   out_ready      in   decode accepts the head
//   out_inst       out  head instruction
//   out_pc4        out  head address + 4
//   occupancy      out  number of queued entries
// -----------------------------------------------------------------------------
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_valid,
  input  logic [XLEN-1:0]          imem_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_inst,
  output logic [XLEN-1:0]          out_pc4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW:0]     OCC_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]     OCC_MAX  = (PW + 1)'(DEPTH);
  localparam logic [PW+1:0]   FILL_MAX = (PW + 2)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_INC = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              inflight_q, inflight_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       occ_q, occ_d;

  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic [PW+1:0]     fill_s;
  logic [2*XLEN-1:0] wr_data_s;
  logic [2*XLEN-1:0] rd_data_s;

  // Handshake decisions for this cycle: request issue, queue push and pop.
  always_comb begin
    fill_s = {1'b0, occ_q} + {{(PW + 1){1'b0}}, inflight_q};
    pop_s  = (occ_q != {(PW + 1){1'b0}}) && out_ready;

    // The outstanding request reserves a slot so a full queue never overflows.
    if ((state_q == ST_RUN) && !redirect_valid && (fill_s < FILL_MAX)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end

    // Only a response we are actually waiting for is captured, and only in RUN.
    if ((state_q == ST_RUN) && imem_valid && inflight_q && !redirect_valid &&
        ((occ_q != OCC_MAX) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    wr_data_s = {imem_data, req_addr_q + WORD_INC};
  end

  // Next-state logic of the fetch controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_DISCARD: begin
        if (redirect_valid) begin
          // A response arriving in the redirect cycle is dropped right here;
          // only a still-pending one needs the DISCARD state.
          if (inflight_q && !imem_valid) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_RUN;
          end
        end else if ((state_q == ST_DISCARD) && imem_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Next values of the fetch PC, in-flight tracking, pointers and occupancy.
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;

    if (issue_s) begin
      inflight_d = 1'b1;
    end else if (imem_valid) begin
      inflight_d = 1'b0;
    end else begin
      inflight_d = inflight_q;
    end

    if (redirect_valid) begin
      // Redirect wins over any push/pop happening in the same cycle.
      pc_d     = redirect_pc & ALIGN_MASK;
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      occ_d    = {(PW + 1){1'b0}};
    end else begin
      if (issue_s) begin
        pc_d       = pc_q + WORD_INC;
        req_addr_d = pc_q;
      end else begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
      end

      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      req_addr_q <= {XLEN{1'b0}};
      inflight_q <= 1'b0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      occ_q      <= {(PW + 1){1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  fifo_ram #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_fifo_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (wr_data_s),
    .raddr (rd_ptr_q),
    .rdata (rd_data_s)
  );

  assign imem_req  = issue_s;
  assign imem_addr = pc_q;
  assign out_valid = (occ_q != {(PW + 1){1'b0}});
  assign out_inst  = rd_data_s[2*XLEN-1:XLEN];
  assign out_pc4   = rd_data_s[XLEN-1:0];
  assign occupancy = occ_q;

endmodule : ifetch_queue

// File: tb/tb_ifetch_queue.sv
// -----------------------------------------------------------------------------
// tb_ifetch_queue
// Directed bench for ifetch_queue. Two instances share clock and reset: the
// main one (RESET_PC = 0) and a second one starting near the top of the
// address space. Each instruction memory model answers one cycle after a
// request with the request address as data.
// -----------------------------------------------------------------------------
module tb_ifetch_queue;

  logic clk = 1'b0;
  logic rst_n;

  // main instance
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic [2:0]  occupancy;

  // wrap instance
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_out_inst;
  logic [31:0] w_out_pc4;
  logic [2:0]  w_occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // memory models: respond one cycle after the request, data = address
  logic        mem_valid_r = 1'b0;
  logic [31:0] mem_data_r  = 32'h0;
  logic        wmem_valid_r = 1'b0;
  logic [31:0] wmem_data_r  = 32'h0;

  always @(posedge clk) begin
    mem_valid_r  <= imem_req;
    mem_data_r   <= imem_addr;
    wmem_valid_r <= w_req;
    wmem_data_r  <= w_addr;
  end

  assign imem_valid = mem_valid_r;
  assign imem_data  = mem_data_r;
  assign w_valid    = wmem_valid_r;
  assign w_data     = wmem_data_r;

  ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc4        (out_pc4),
    .occupancy      (occupancy)
  );

  ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_valid     (w_valid),
    .imem_data      (w_data),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .out_valid      (w_out_valid),
    .out_ready      (w_out_ready),
    .out_inst       (w_out_inst),
    .out_pc4        (w_out_pc4),
    .occupancy      (w_occupancy)
  );

  // advance one clock and settle away from the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // hold reset for two edges, release between edges (DUT now in BOOT)
  task automatic do_reset(input logic ready);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = ready;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=0", imem_addr); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL boot_req got=%0b exp=0", imem_req); end
  endtask

  // continues from BOOT left by test_reset
  task automatic test_stream();
    for (int k = 0; k < 9; k++) begin
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_bad++; $display("FAIL stream_req c%0d got=%0b/%h exp=1/%h", k, imem_req, imem_addr, 32'(4 * k));
      end
      if (k >= 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'(4 * (k - 2)) || out_pc4 !== 32'(4 * (k - 1))) begin
          n_bad++; $display("FAIL stream_head c%0d got=%0b/%h/%h exp=1/%h/%h", k, out_valid, out_inst, out_pc4,
                            32'(4 * (k - 2)), 32'(4 * (k - 1)));
        end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early c%0d got=%0b exp=0", k, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_occ [10] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (occupancy !== 3'(exp_occ[c])) begin
        n_bad++; $display("FAIL bp_occ c%0d got=%0d exp=%0d", c, occupancy, exp_occ[c]);
      end
      n_cmp++; if (imem_req !== ((c < 4) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL bp_req c%0d got=%0b exp=%0b", c, imem_req, (c < 4) ? 1'b1 : 1'b0);
      end
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_pc4 !== 32'h4 || out_inst !== 32'h0) begin
          n_bad++; $display("FAIL bp_hold c%0d got=%0b/%h/%h exp=1/00000004/00000000", c, out_valid, out_pc4, out_inst);
        end
      end
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc4 !== 32'(4 * (j + 1)) || out_inst !== 32'(4 * j)) begin
        n_bad++; $display("FAIL bp_drain %0d got=%0b/%h/%h exp=1/%h/%h", j, out_valid, out_pc4, out_inst,
                          32'(4 * (j + 1)), 32'(4 * j));
      end
      if (j == 1) begin
        n_cmp++; if (occupancy !== 3'd3 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
          n_bad++; $display("FAIL bp_resume got=%0d/%h/%0b exp=3/00000010/1", occupancy, imem_addr, imem_req);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    repeat (5) tick();                       // cycle 4: response of request 12 landing
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_suppress got=%0b exp=0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_flush got=%0d/%0b exp=0/0", occupancy, out_valid);
    end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_bad++; $display("FAIL redir_fetch got=%0b/%h exp=1/00000100", imem_req, imem_addr);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_bad++; $display("FAIL redir_stale got=%0b/%0d exp=0/0", out_valid, occupancy);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc4 !== 32'h104 || out_inst !== 32'h100) begin
      n_bad++; $display("FAIL redir_head got=%0b/%h/%h exp=1/00000104/00000100", out_valid, out_pc4, out_inst);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_pc = 32'h300;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second got=%0b/%0b exp=0/0", imem_req, out_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_fetch got=%0b/%h/%0b exp=1/00000300/0", imem_req, imem_addr, out_valid);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got=%0b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc4 !== 32'h304 || out_inst !== 32'h300) begin
      n_bad++; $display("FAIL b2b_head got=%0b/%h/%h exp=1/00000304/00000300", out_valid, out_pc4, out_inst);
    end
    // misaligned target: low two bits are dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10A;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h108) begin n_bad++; $display("FAIL align_addr got=%h exp=00000108", imem_addr); end
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc4 !== 32'h10C) begin
      n_bad++; $display("FAIL align_head got=%0b/%h exp=1/0000010c", out_valid, out_pc4);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    logic [31:0] exp_pc4  [5] = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
    do_reset(1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (w_req !== 1'b1 || w_addr !== exp_addr[c]) begin
        n_bad++; $display("FAIL wrap_addr c%0d got=%0b/%h exp=1/%h", c, w_req, w_addr, exp_addr[c]);
      end
      if (c >= 2) begin
        n_cmp++; if (w_out_valid !== 1'b1 || w_out_pc4 !== exp_pc4[c]) begin
          n_bad++; $display("FAIL wrap_pc4 c%0d got=%0b/%h exp=1/%h", c, w_out_valid, w_out_pc4, exp_pc4[c]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset(1'b0);
    repeat (5) tick();
    n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL rst_pre_occ got=%0d exp=3", occupancy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL rst_async got=%0b/%0d/%0b exp=0/0/0", out_valid, occupancy, imem_req);
    end
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_boot_req got=%0b exp=0", imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || occupancy !== 3'd0) begin
      n_bad++; $display("FAIL rst_refetch got=%0b/%h/%0d exp=1/00000000/0", imem_req, imem_addr, occupancy);
    end
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc4 !== 32'h4 || out_inst !== 32'h0) begin
      n_bad++; $display("FAIL rst_head got=%0b/%h/%h exp=1/00000004/00000000", out_valid, out_pc4, out_inst);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ifetch_queue
